// File: rtl/alu_sys_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_sys_pkg: command bytes, controller states, ALU function codes |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package alu_sys_pkg;

    localparam logic [7:0] CMD_ALU_OPER = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_A   = 3'd1,
        WAIT_B   = 3'd2,
        WAIT_FUN = 3'd3,
        ALU_GO   = 3'd4,
        WAIT_RES = 3'd5,
        SEND_LO  = 3'd6,
        SEND_HI  = 3'd7
    } ctrl_state_t;

    localparam logic [3:0] ALU_FUN_ADD   = 4'h0;
    localparam logic [3:0] ALU_FUN_SUB   = 4'h1;
    localparam logic [3:0] ALU_FUN_MUL   = 4'h2;
    localparam logic [3:0] ALU_FUN_DIV   = 4'h3;
    localparam logic [3:0] ALU_FUN_AND   = 4'h4;
    localparam logic [3:0] ALU_FUN_OR    = 4'h5;
    localparam logic [3:0] ALU_FUN_NAND  = 4'h6;
    localparam logic [3:0] ALU_FUN_NOR   = 4'h7;
    localparam logic [3:0] ALU_FUN_XOR   = 4'h8;
    localparam logic [3:0] ALU_FUN_XNOR  = 4'h9;
    localparam logic [3:0] ALU_FUN_CMPEQ = 4'hA;
    localparam logic [3:0] ALU_FUN_CMPGT = 4'hB;
    localparam logic [3:0] ALU_FUN_CMPLT = 4'hC;
    localparam logic [3:0] ALU_FUN_SHR   = 4'hD;
    localparam logic [3:0] ALU_FUN_SHL   = 4'hE;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_cmd_ctrl_if: RX, ALU and TX signals of the command controller |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface alu_cmd_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   RX_P_DATA;
    logic               RX_D_VLD;
    logic [WIDTH-1:0]   ALU_A;
    logic [WIDTH-1:0]   ALU_B;
    logic [3:0]         ALU_FUN;
    logic               ALU_EN;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               ALU_Valid;
    logic [WIDTH-1:0]   TX_P_DATA;
    logic               TX_D_VLD;
    logic               TX_BUSY;
    logic               CMD_ERR;

    // master is the controller; slave is the UART/ALU side facing it
    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_Valid, TX_BUSY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_Valid, TX_BUSY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_cmd_ctrl: parses RX frames, pulses the ALU, sends result LSB 1st|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire            CLK,
    input  wire            RST,
    alu_cmd_ctrl_if.master bus
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_nxt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   w_alu_a_nxt;
    logic [WIDTH-1:0]   r_alu_b;
    logic [WIDTH-1:0]   w_alu_b_nxt;
    logic [3:0]         r_alu_fun;
    logic [3:0]         w_alu_fun_nxt;
    logic               r_alu_en;
    logic               w_alu_en_nxt;
    logic               r_cmd_err;
    logic               w_cmd_err_nxt;
    logic [2*WIDTH-1:0] r_res;
    logic [2*WIDTH-1:0] w_res_nxt;
    logic               w_tx_vld;
    logic [WIDTH-1:0]   w_tx_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_alu_en  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_res     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_alu_fun <= w_alu_fun_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_res     <= w_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_fun_nxt = r_alu_fun;
        w_alu_en_nxt  = 1'b0;
        w_cmd_err_nxt = 1'b0;
        w_res_nxt     = r_res;
        w_tx_vld      = 1'b0;
        w_tx_data     = '0;

        case (r_state)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == WIDTH'(CMD_ALU_OPER)) begin
                        w_state_nxt = WAIT_A;
                    end else if (bus.RX_P_DATA == WIDTH'(CMD_ALU_NOP)) begin
                        w_state_nxt = WAIT_FUN;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            WAIT_A: begin
                if (bus.RX_D_VLD) begin
                    w_alu_a_nxt = bus.RX_P_DATA;
                    w_state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.RX_D_VLD) begin
                    w_alu_b_nxt = bus.RX_P_DATA;
                    w_state_nxt = WAIT_FUN;
                end
            end
            WAIT_FUN: begin
                // enable is registered so it is high exactly while in ALU_GO
                if (bus.RX_D_VLD) begin
                    w_alu_fun_nxt = bus.RX_P_DATA[3:0];
                    w_alu_en_nxt  = 1'b1;
                    w_state_nxt   = ALU_GO;
                end
            end
            ALU_GO: begin
                w_state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                // ALU_Valid is a level that lingers; only trust it here
                if (bus.ALU_Valid) begin
                    w_res_nxt   = bus.ALU_OUT;
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                w_tx_vld  = 1'b1;
                w_tx_data = r_res[WIDTH-1:0];
                if (!bus.TX_BUSY) begin
                    w_state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                w_tx_vld  = 1'b1;
                w_tx_data = r_res[2*WIDTH-1:WIDTH];
                if (!bus.TX_BUSY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ALU_A     = r_alu_a;
    assign bus.ALU_B     = r_alu_b;
    assign bus.ALU_FUN   = r_alu_fun;
    assign bus.ALU_EN    = r_alu_en;
    assign bus.CMD_ERR   = r_cmd_err;
    assign bus.TX_D_VLD  = w_tx_vld;
    assign bus.TX_P_DATA = w_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_cmd_ctrl: directed + random frames against a frame model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_alu_cmd_ctrl;
    import alu_sys_pkg::*;

    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic RST;

    alu_cmd_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_cmd_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // reference state: what the controller must hold after each frame
    logic [7:0] m_a   = 8'h00;
    logic [7:0] m_b   = 8'h00;
    logic [3:0] m_fun = 4'h0;
    int         exp_en  = 0;
    int         exp_err = 0;

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (f)
            ALU_FUN_ADD:   return x + y;
            ALU_FUN_SUB:   return x - y;
            ALU_FUN_MUL:   return x * y;
            ALU_FUN_DIV:   return (b == 8'h00) ? 16'h0000 : x / y;
            ALU_FUN_AND:   return {8'h00, a & b};
            ALU_FUN_OR:    return {8'h00, a | b};
            ALU_FUN_NAND:  return {8'h00, ~(a & b)};
            ALU_FUN_NOR:   return {8'h00, ~(a | b)};
            ALU_FUN_XOR:   return {8'h00, a ^ b};
            ALU_FUN_XNOR:  return {8'h00, ~(a ^ b)};
            ALU_FUN_CMPEQ: return (a == b) ? 16'd1 : 16'd0;
            ALU_FUN_CMPGT: return (a > b) ? 16'd2 : 16'd0;
            ALU_FUN_CMPLT: return (a < b) ? 16'd3 : 16'd0;
            ALU_FUN_SHR:   return x >> 1;
            ALU_FUN_SHL:   return x << 1;
            default:       return 16'h0000;
        endcase
    endfunction

    // registered ALU: result appears the cycle after ALU_EN, valid stays high
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.ALU_OUT   <= '0;
            bus.ALU_Valid <= 1'b0;
        end else if (bus.ALU_EN) begin
            bus.ALU_OUT   <= alu_ref(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
            bus.ALU_Valid <= 1'b1;
        end
    end

    // transmitter: busy for tx_len cycles after each accepted byte
    int   tx_len   = 1;
    int   tx_cnt   = 0;
    logic tx_force = 1'b0;
    assign bus.TX_BUSY = tx_force || (tx_cnt != 0);

    always @(posedge CLK or negedge RST) begin
        if (!RST) tx_cnt <= 0;
        else if (bus.TX_D_VLD && !bus.TX_BUSY) tx_cnt <= tx_len;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    logic [7:0] obs_q[$];
    int en_cnt  = 0;
    int err_cnt = 0;

    always @(negedge CLK) begin
        if (bus.TX_D_VLD && !bus.TX_BUSY) obs_q.push_back(bus.TX_P_DATA);
        if (bus.ALU_EN) en_cnt++;
        if (bus.CMD_ERR) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // all tasks start and end at #1 after a rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        step();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic send_bad_cmd(input logic [7:0] b);
        send_byte(b);
        exp_err++;
        check("cmd_err_pulse", bus.CMD_ERR, 1);
        step();
        check("cmd_err_width", bus.CMD_ERR, 0);
        repeat (2) step();
        check("cmd_err_no_tx", obs_q.size(), 0);
        check("cmd_err_no_en", en_cnt, exp_en);
        check("cmd_err_count", err_cnt, exp_err);
    endtask

    // returns in the cycle the low byte is first offered
    task automatic run_frame(input bit oper, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fb, input bit gaps);
        logic [15:0] r;
        if (oper) begin
            send_byte(CMD_ALU_OPER); gap(gaps);
            send_byte(a);            gap(gaps);
            send_byte(b);            gap(gaps);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(CMD_ALU_NOP);  gap(gaps);
        end
        send_byte(fb);
        m_fun = fb[3:0];
        exp_en++;
        r = alu_ref(m_a, m_b, m_fun);
        check("alu_en_latency", bus.ALU_EN, 1);
        step();
        check("alu_en_width", bus.ALU_EN, 0);
        step();
        check("tx_first_vld", bus.TX_D_VLD, 1);
        check("tx_first_data", bus.TX_P_DATA, r[7:0]);
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] r;
        logic [7:0]  lo;
        logic [7:0]  hi;
        r = alu_ref(m_a, m_b, m_fun);
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= 2) break;
            step();
        end
        check({tag, "_tx_count"}, obs_q.size(), 2);
        lo = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        hi = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        check({tag, "_tx_lo"}, lo, r[7:0]);
        check({tag, "_tx_hi"}, hi, r[15:8]);
        check({tag, "_alu_a"}, bus.ALU_A, m_a);
        check({tag, "_alu_b"}, bus.ALU_B, m_b);
        check({tag, "_alu_fun"}, bus.ALU_FUN, m_fun);
        check({tag, "_en_count"}, en_cnt, exp_en);
        check({tag, "_err_count"}, err_cnt, exp_err);
        repeat (3) step();
        check({tag, "_no_extra_tx"}, obs_q.size(), 0);
        check({tag, "_tx_idle"}, bus.TX_D_VLD, 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rf;
        logic [7:0] bad;
        logic [15:0] r;
        bit         op;

        RST           = 1'b0;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        repeat (3) step();
        check("rst_alu_a", bus.ALU_A, 0);
        check("rst_alu_b", bus.ALU_B, 0);
        check("rst_alu_fun", bus.ALU_FUN, 0);
        check("rst_alu_en", bus.ALU_EN, 0);
        check("rst_cmd_err", bus.CMD_ERR, 0);
        check("rst_tx_vld", bus.TX_D_VLD, 0);
        check("rst_tx_data", bus.TX_P_DATA, 0);
        RST = 1'b1;
        step();

        // NOP straight after reset works on A=B=0
        run_frame(1'b0, 8'h00, 8'h00, {4'h0, ALU_FUN_NAND}, 1'b0);
        check_frame("nop_after_rst");

        run_frame(1'b1, 8'h05, 8'h03, 8'h00, 1'b0);
        check_frame("add_5_3");

        run_frame(1'b0, 8'h00, 8'h00, 8'h02, 1'b0);
        check_frame("nop_mul_reuse");

        send_bad_cmd(8'h55);
        run_frame(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0);
        check_frame("add_ff_ff");

        // low byte must stay put through a long busy stretch
        tx_force = 1'b1;
        run_frame(1'b1, 8'h9A, 8'h37, 8'hF1, 1'b0);
        r = alu_ref(m_a, m_b, m_fun);
        for (int i = 0; i < 10; i++) begin
            check("busy_vld_hold", bus.TX_D_VLD, 1);
            check("busy_data_hold", bus.TX_P_DATA, r[7:0]);
            step();
        end
        check("busy_no_xfer", obs_q.size(), 0);
        tx_force = 1'b0;
        check_frame("busy_release");

        // reset in the middle of a frame drops it
        send_byte(CMD_ALU_OPER);
        send_byte(8'h05);
        RST = 1'b0;
        #3;
        check("midrst_alu_a", bus.ALU_A, 0);
        check("midrst_alu_b", bus.ALU_B, 0);
        check("midrst_alu_fun", bus.ALU_FUN, 0);
        check("midrst_alu_en", bus.ALU_EN, 0);
        check("midrst_tx_vld", bus.TX_D_VLD, 0);
        check("midrst_cmd_err", bus.CMD_ERR, 0);
        step();
        RST   = 1'b1;
        m_a   = 8'h00;
        m_b   = 8'h00;
        m_fun = 4'h0;
        step();
        run_frame(1'b1, 8'h02, 8'h02, 8'h02, 1'b0);
        check_frame("after_midrst");

        // bytes arriving while the high byte waits are ignored
        tx_len = 6;
        run_frame(1'b1, 8'h40, 8'h0C, 8'h01, 1'b0);
        step();
        send_byte(8'h11);
        send_byte(8'h22);
        check_frame("drop_in_send_hi");
        tx_len = 1;
        run_frame(1'b0, 8'h00, 8'h00, 8'h03, 1'b0);
        check_frame("idle_after_drop");

        for (int it = 0; it < 12; it++) begin
            tx_len = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do bad = 8'($urandom); while (bad == CMD_ALU_OPER || bad == CMD_ALU_NOP);
                send_bad_cmd(bad);
            end
            op = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rf = {4'($urandom), 4'($urandom_range(0, 14))};
            run_frame(op, ra, rb, rf, 1'b1);
            check_frame("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
